// File: rtl/fanout_fork_ctrl.sv
// Eager-fork broadcast point: one upstream ready/valid stream delivered to every
// enabled downstream port, each accepting at its own pace, with no duplicates.
module fanout_fork_ctrl #(
  parameter int NUM_OUT    = 6,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_OUT-1:0]    cfg_en,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [NUM_OUT-1:0]    out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic [NUM_OUT-1:0]    out_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  typedef enum logic {IDLE, PARTIAL} state_t;

  state_t               state, state_next;
  logic [NUM_OUT-1:0]   done, done_next;
  logic [NUM_OUT-1:0]   fire;
  logic                 retire;

  // Disabled or already-served ports count as ready so the token can retire.
  always_comb begin
    out_valid  = {NUM_OUT{in_valid & ~flush}} & cfg_en & ~done;
    fire       = out_valid & out_ready;
    in_ready   = ~flush & (&(~cfg_en | done | out_ready));
    out_data   = in_data;
    retire     = in_valid & in_ready;
    busy       = (state == PARTIAL);
    done_next  = (done | fire) & cfg_en;
    state_next = (done_next != '0) ? PARTIAL : IDLE;
    if (flush || retire) begin
      done_next  = '0;
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      done       <= '0;
      xfer_count <= '0;
    end else begin
      state <= state_next;
      done  <= done_next;
      if (retire)
        xfer_count <= xfer_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// Directed bench for fanout_fork_ctrl; a second instance with a 4-bit counter
// shares the stimulus so the wrap behaviour can be seen in a short run.
module tb_fanout_fork_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  cfg_en;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic [5:0]  out_ready;

  logic        in_ready, busy;
  logic [5:0]  out_valid;
  logic [15:0] out_data;
  logic [15:0] xfer_count;

  logic        w_in_ready, w_busy;
  logic [5:0]  w_out_valid;
  logic [15:0] w_out_data;
  logic [3:0]  w_xfer_count;

  int vectors = 0;
  int miscompares = 0;
  int retires = 0;

  always #5 clk = ~clk;

  fanout_fork_ctrl dut (
    .clk(clk), .reset(reset), .cfg_en(cfg_en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .xfer_count(xfer_count)
  );

  fanout_fork_ctrl #(.NUM_OUT(6), .DATA_WIDTH(16), .CNT_WIDTH(4)) dutw (
    .clk(clk), .reset(reset), .cfg_en(cfg_en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(w_in_ready),
    .out_valid(w_out_valid), .out_data(w_out_data), .out_ready(out_ready),
    .busy(w_busy), .xfer_count(w_xfer_count)
  );

  task automatic applyStimulus(input logic [5:0] en, input logic fl, input logic v,
                               input logic [15:0] d, input logic [5:0] rdy);
    cfg_en    = en;
    flush     = fl;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCounts(input string tag);
    checkOutput({tag, "_cnt16"}, 32'(xfer_count), 32'(retires & 16'hFFFF));
    checkOutput({tag, "_cnt4"}, 32'(w_xfer_count), 32'(retires % 16));
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(6'h3F, 1'b0, 1'b0, 16'h0, 6'h00);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'h00);
    checkOutput("rst_ready", 32'(in_ready), 32'd0);
    checkCounts("rst");

    // Full broadcast, one token per cycle.
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(6'h3F, 1'b0, 1'b1, 16'(k), 6'h3F);
      checkOutput("bc_valid", 32'(out_valid), 32'h3F);
      checkOutput("bc_data", 32'(out_data), 32'(k));
      checkOutput("bc_ready", 32'(in_ready), 32'd1);
      checkOutput("bc_busy", 32'(busy), 32'd0);
      tick();
      retires++;
      checkCounts("bc");
    end

    // Staggered accept on three ports.
    applyStimulus(6'h07, 1'b0, 1'b1, 16'h0055, 6'b000001);
    checkOutput("st0_valid", 32'(out_valid), 32'h07);
    checkOutput("st0_ready", 32'(in_ready), 32'd0);
    tick();
    applyStimulus(6'h07, 1'b0, 1'b1, 16'h0055, 6'b000000);
    checkOutput("st1_valid", 32'(out_valid), 32'h06);
    checkOutput("st1_busy", 32'(busy), 32'd1);
    tick();
    applyStimulus(6'h07, 1'b0, 1'b1, 16'h0055, 6'b000010);
    checkOutput("st2_valid", 32'(out_valid), 32'h06);
    checkOutput("st2_ready", 32'(in_ready), 32'd0);
    tick();
    applyStimulus(6'h07, 1'b0, 1'b1, 16'h0055, 6'b000000);
    checkOutput("st3_valid", 32'(out_valid), 32'h04);
    checkOutput("st3_busy", 32'(busy), 32'd1);
    tick();
    applyStimulus(6'h07, 1'b0, 1'b1, 16'h0055, 6'b000000);
    checkOutput("st4_valid", 32'(out_valid), 32'h04);
    checkOutput("st4_ready", 32'(in_ready), 32'd0);
    tick();
    applyStimulus(6'h07, 1'b0, 1'b1, 16'h0055, 6'b000100);
    checkOutput("st5_ready", 32'(in_ready), 32'd1);
    checkOutput("st5_busy", 32'(busy), 32'd1);
    tick();
    retires++;
    applyStimulus(6'h07, 1'b0, 1'b1, 16'h0066, 6'b000000);
    checkOutput("st6_busy", 32'(busy), 32'd0);
    checkOutput("st6_valid", 32'(out_valid), 32'h07);
    checkCounts("st6");
    in_valid = 1'b0;
    #1;
    checkOutput("st6_novalid", 32'(out_valid), 32'h00);

    // No destinations enabled: tokens are swallowed.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(6'h00, 1'b0, 1'b1, 16'(16'hA0 + k), 6'h00);
      checkOutput("ds_ready", 32'(in_ready), 32'd1);
      checkOutput("ds_valid", 32'(out_valid), 32'h00);
      tick();
      retires++;
    end
    checkCounts("ds");

    // Flush mid-token.
    applyStimulus(6'h03, 1'b0, 1'b1, 16'h0077, 6'b01);
    checkOutput("fl0_valid", 32'(out_valid), 32'h03);
    tick();
    applyStimulus(6'h03, 1'b0, 1'b1, 16'h0077, 6'b00);
    checkOutput("fl1_valid", 32'(out_valid), 32'h02);
    checkOutput("fl1_busy", 32'(busy), 32'd1);
    tick();
    applyStimulus(6'h03, 1'b1, 1'b1, 16'h0077, 6'b11);
    checkOutput("fl2_valid", 32'(out_valid), 32'h00);
    checkOutput("fl2_ready", 32'(in_ready), 32'd0);
    tick();
    applyStimulus(6'h03, 1'b0, 1'b1, 16'h0077, 6'b00);
    checkOutput("fl3_busy", 32'(busy), 32'd0);
    checkOutput("fl3_valid", 32'(out_valid), 32'h03);
    checkCounts("fl3");
    applyStimulus(6'h03, 1'b0, 1'b1, 16'h0077, 6'b11);
    checkOutput("fl4_ready", 32'(in_ready), 32'd1);
    tick();
    retires++;
    checkCounts("fl4");

    // Counter wrap on the 4-bit instance, starting from reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    retires = 0;
    checkCounts("wr_rst");
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(6'h00, 1'b0, 1'b1, 16'(k), 6'h00);
      tick();
      retires++;
      if (k >= 15) checkCounts("wr");
    end
    checkOutput("wr_final", 32'(w_xfer_count), 32'd1);

    // Reset in the middle of a delivery re-offers the token.
    applyStimulus(6'h03, 1'b0, 1'b1, 16'h0088, 6'b10);
    checkOutput("rm0_valid", 32'(out_valid), 32'h03);
    tick();
    applyStimulus(6'h03, 1'b0, 1'b1, 16'h0088, 6'b00);
    checkOutput("rm1_valid", 32'(out_valid), 32'h01);
    checkOutput("rm1_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    retires = 0;
    #1;
    checkOutput("rm2_busy", 32'(busy), 32'd0);
    checkOutput("rm2_valid", 32'(out_valid), 32'h03);
    checkCounts("rm2");
    applyStimulus(6'h03, 1'b0, 1'b1, 16'h0088, 6'b11);
    checkOutput("rm3_ready", 32'(in_ready), 32'd1);
    tick();
    retires++;
    checkCounts("rm3");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
